// File: rtl/led_pattern_engine.sv
// LED pattern engine: run / fill-drain / auto-sequence / bounce patterns on an LED_W-bit register.
// Latency: a mode change loads its seed on that clock edge; a step updates Led on the qualified en edge.
// Backpressure: none; en is a step strobe and the divider holds while en is low. Bounce needs LED_BOUNCE_EN.
module led_pattern_engine #(
   parameter int LED_W    = 27,
   parameter int RUN_W    = 3,
   parameter int STEP_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             en,
   input  logic             LR,
   output logic [LED_W-1:0] Led,
   output logic [1:0]       phase,
   output logic             wrap
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int LO_W  = LED_W / 2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   localparam logic [LED_W-1:0] SEED_L = {{(LED_W-RUN_W){1'b0}}, {RUN_W{1'b1}}};
   localparam logic [LED_W-1:0] SEED_R = {{RUN_W{1'b1}}, {(LED_W-RUN_W){1'b0}}};
   localparam logic [LED_W-1:0] SEED_F = {1'b1, {(LED_W-2){1'b0}}, 1'b1};
   localparam logic [LED_W-1:0] ALL1   = {LED_W{1'b1}};

   localparam logic [2:0] MODE_OFF    = 3'b000;
   localparam logic [2:0] MODE_RUN    = 3'b001;
   localparam logic [2:0] MODE_FILL   = 3'b010;
   localparam logic [2:0] MODE_AUTO   = 3'b011;
`ifdef LED_BOUNCE_EN
   localparam logic [2:0] MODE_BOUNCE = 3'b100;
`endif

   typedef enum logic [1:0] {
      PH_RUN_L = 2'b00,
      PH_RUN_R = 2'b01,
      PH_FILL  = 2'b10,
      PH_DRAIN = 2'b11
   } phase_e;

   logic [LED_W-1:0] led_q, led_d;
   phase_e           phase_q, phase_d;
   logic             wrap_q, wrap_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       prev_mode_q;
`ifdef LED_BOUNCE_EN
   logic             dir_q, dir_d;   // 0 = moving left, 1 = moving right
`endif

   logic             step;
   logic [LED_W-1:0] run_l_sh, run_r_sh, fill_sh, drain_sh;

   // Candidate next patterns for each step flavour.
   always_comb begin
      run_l_sh = led_q << RUN_W;
      run_r_sh = led_q >> RUN_W;
      // lower half grows upward from bit 0, upper half grows downward from the top bit
      fill_sh  = {1'b1, led_q[LED_W-1:LO_W+1], led_q[LO_W-2:0], 1'b1};
      drain_sh = led_q >> 1;
   end

   // Divider, seed load on mode change, and per-mode step / wrap decision.
   always_comb begin
      led_d   = led_q;
      phase_d = PH_RUN_L;
      wrap_d  = 1'b0;
      div_d   = div_q;
      step    = 1'b0;
`ifdef LED_BOUNCE_EN
      dir_d   = dir_q;
`endif
      if (mode != prev_mode_q) begin
         // mode-change cycle: seed only, never a step
         div_d = '0;
         case (mode)
            MODE_RUN:    led_d = LR ? SEED_R : SEED_L;
            MODE_FILL:   led_d = SEED_F;
            MODE_AUTO:   led_d = SEED_L;
`ifdef LED_BOUNCE_EN
            MODE_BOUNCE: begin
               led_d = LR ? SEED_R : SEED_L;
               dir_d = LR;
            end
`endif
            default:     led_d = '0;
         endcase
      end else begin
         if (en) begin
            if (div_q == DIV_LAST) begin
               step  = 1'b1;
               div_d = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         case (mode)
            MODE_RUN: if (step) begin
               if (LR) begin
                  if (run_r_sh == '0) begin
                     led_d  = SEED_R;
                     wrap_d = 1'b1;
                  end else begin
                     led_d = run_r_sh;
                  end
               end else begin
                  if (run_l_sh == '0) begin
                     led_d  = SEED_L;
                     wrap_d = 1'b1;
                  end else begin
                     led_d = run_l_sh;
                  end
               end
            end
            MODE_FILL: if (step) begin
               if (LR)                 led_d = drain_sh;
               else if (led_q != ALL1) led_d = fill_sh;
            end
            MODE_AUTO: begin
               phase_d = phase_q;
               if (step) begin
                  unique case (phase_q)
                     PH_RUN_L: if (run_l_sh == '0) begin
                        phase_d = PH_RUN_R;
                        led_d   = SEED_R;
                        wrap_d  = 1'b1;
                     end else begin
                        led_d = run_l_sh;
                     end
                     PH_RUN_R: if (run_r_sh == '0) begin
                        phase_d = PH_FILL;
                        led_d   = SEED_F;
                        wrap_d  = 1'b1;
                     end else begin
                        led_d = run_r_sh;
                     end
                     PH_FILL: if (led_q == ALL1) begin
                        phase_d = PH_DRAIN;
                        wrap_d  = 1'b1;
                     end else begin
                        led_d = fill_sh;
                     end
                     PH_DRAIN: if (led_q == '0) begin
                        phase_d = PH_RUN_L;
                        led_d   = SEED_L;
                        wrap_d  = 1'b1;
                     end else begin
                        led_d = drain_sh;
                     end
                  endcase
               end
            end
`ifdef LED_BOUNCE_EN
            MODE_BOUNCE: if (step) begin
               if (!dir_q) begin
                  if (led_q[LED_W-1]) begin
                     dir_d  = 1'b1;
                     led_d  = led_q >> 1;
                     wrap_d = 1'b1;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q[0]) begin
                     dir_d  = 1'b0;
                     led_d  = led_q << 1;
                     wrap_d = 1'b1;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
`endif
            default: led_d = '0;
         endcase
      end
   end

   // State registers with synchronous reset that dominates everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_q       <= '0;
         phase_q     <= PH_RUN_L;
         wrap_q      <= 1'b0;
         div_q       <= '0;
         prev_mode_q <= MODE_OFF;
`ifdef LED_BOUNCE_EN
         dir_q       <= 1'b0;
`endif
      end else begin
         led_q       <= led_d;
         phase_q     <= phase_d;
         wrap_q      <= wrap_d;
         div_q       <= div_d;
         prev_mode_q <= mode;
`ifdef LED_BOUNCE_EN
         dir_q       <= dir_d;
`endif
      end
   end

   assign Led   = led_q;
   assign phase = phase_q;
   assign wrap  = wrap_q;

endmodule
